// File: rtl/kmer_stream_gen.sv
// kmer_stream_gen: slides a K-base window across a packed 2-bit read and
// streams one k-mer per accepted handshake, first base in the MSBs.
// A read is captured whole into a shift register; each emitted k-mer is the
// top 2*K bits, and advancing shifts the register left by STRIDE bases.
module kmer_stream_gen #(
  parameter int unsigned READ_BASES = 256,
  parameter int unsigned K          = 45,
  parameter int unsigned STRIDE     = 1,
  parameter int unsigned POS_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [2*READ_BASES-1:0] rd_data,
  input  logic [POS_W:0]          rd_len,
  input  logic                    flush,
  output logic                    km_valid,
  input  logic                    km_ready,
  output logic [2*K-1:0]          km_data,
  output logic [POS_W-1:0]        km_pos,
  output logic                    km_last,
  output logic                    busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  localparam int unsigned SR_W = 2 * READ_BASES;
  localparam int unsigned KM_W = 2 * K;

  // Wide copies of the geometry so end-of-window arithmetic cannot wrap.
  localparam logic [POS_W+1:0] READ_BASES_X = (POS_W+2)'(READ_BASES);
  localparam logic [POS_W+1:0] K_X          = (POS_W+2)'(K);
  localparam logic [POS_W+1:0] STRIDE_X     = (POS_W+2)'(STRIDE);
  localparam logic [POS_W-1:0] STRIDE_P     = POS_W'(STRIDE);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [SR_W-1:0]  shreg;
  logic [POS_W:0]   len;
  logic [POS_W-1:0] pos;

  logic [POS_W:0]   len_clamped;
  logic [POS_W+1:0] next_end;
  logic             last_raw;
  logic             accept;
  logic             advance;

  // Clamp the offered length to the register capacity.
  always_comb begin
    len_clamped = rd_len;
    if ({1'b0, rd_len} > READ_BASES_X)
      len_clamped = READ_BASES_X[POS_W:0];
  end

  // Window bookkeeping: the current k-mer is last when the next window
  // would run past the captured length.
  always_comb begin
    next_end = {2'b00, pos} + STRIDE_X + K_X;
    last_raw = (next_end > {1'b0, len});
    accept   = (state == IDLE) && rd_valid && !flush;
    advance  = (state == EMIT) && km_ready && !flush && !last_raw;
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept && ({1'b0, len_clamped} >= K_X)) state_nxt = EMIT;
        EMIT: if (km_ready && last_raw)                   state_nxt = IDLE;
        default:                                          state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Read capture and stride advance of the shift register and position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      len   <= '0;
      pos   <= '0;
    end else if (accept) begin
      shreg <= rd_data;
      len   <= len_clamped;
      pos   <= '0;
    end else if (advance) begin
      shreg <= shreg << (2 * STRIDE);
      pos   <= pos + STRIDE_P;
    end
  end

  // Outputs are pure functions of the registered state, so they hold
  // stable for as long as the consumer stalls.
  always_comb begin
    rd_ready = (state == IDLE);
    busy     = (state == EMIT);
    km_valid = (state == EMIT);
    km_data  = shreg[SR_W-1 -: KM_W];
    km_pos   = pos;
    km_last  = (state == EMIT) && last_raw;
  end

endmodule

// File: tb/tb_kmer_stream_gen.sv
// Bench for kmer_stream_gen: default-geometry instance plus a STRIDE=4
// instance, checked against a base-indexed k-mer reference model.
module tb_kmer_stream_gen;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_valid;
  logic [511:0] rd_data;
  logic [8:0]   rd_len;
  logic         flush;
  logic         km_ready;
  logic         sel;

  logic         rd_valid_a, rd_ready_a, km_valid_a, km_last_a, busy_a;
  logic [89:0]  km_data_a;
  logic [7:0]   km_pos_a;
  logic         rd_valid_b, rd_ready_b, km_valid_b, km_last_b, busy_b;
  logic [89:0]  km_data_b;
  logic [7:0]   km_pos_b;

  logic         cur_rd_ready, cur_km_valid, cur_km_last, cur_busy;
  logic [89:0]  cur_km_data;
  logic [7:0]   cur_km_pos;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rd_valid_a = rd_valid & ~sel;
  assign rd_valid_b = rd_valid & sel;

  assign cur_rd_ready = sel ? rd_ready_b : rd_ready_a;
  assign cur_km_valid = sel ? km_valid_b : km_valid_a;
  assign cur_km_last  = sel ? km_last_b  : km_last_a;
  assign cur_busy     = sel ? busy_b     : busy_a;
  assign cur_km_data  = sel ? km_data_b  : km_data_a;
  assign cur_km_pos   = sel ? km_pos_b   : km_pos_a;

  kmer_stream_gen dut_a (
    .clk(clk), .reset(reset), .rd_valid(rd_valid_a), .rd_ready(rd_ready_a),
    .rd_data(rd_data), .rd_len(rd_len), .flush(flush), .km_valid(km_valid_a),
    .km_ready(km_ready), .km_data(km_data_a), .km_pos(km_pos_a),
    .km_last(km_last_a), .busy(busy_a)
  );

  kmer_stream_gen #(.READ_BASES(256), .K(45), .STRIDE(4), .POS_W(8)) dut_b (
    .clk(clk), .reset(reset), .rd_valid(rd_valid_b), .rd_ready(rd_ready_b),
    .rd_data(rd_data), .rd_len(rd_len), .flush(flush), .km_valid(km_valid_b),
    .km_ready(km_ready), .km_data(km_data_b), .km_pos(km_pos_b),
    .km_last(km_last_b), .busy(busy_b)
  );

  // Reference: bases p..p+44 of the read, base j at bits [511-2j -: 2].
  function automatic logic [89:0] model_kmer(input logic [511:0] rd, input int p);
    logic [89:0] r;
    r = '0;
    for (int i = 0; i < 45; i++) r = {r[87:0], rd[511-2*(p+i) -: 2]};
    return r;
  endfunction

  function automatic logic [511:0] rand_read();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Offer one read to the selected instance and follow its k-mer stream.
  // abort_kind: 0 none, 1 flush, 2 reset, applied during the k-mer at abort_pos.
  task automatic do_read(input logic [511:0] rd, input int rl, input bit stall,
                         input int abort_kind, input int abort_pos, input string tag);
    int le, stride, nexp, idx, cyc;
    bit hs, aborted;
    logic [89:0] exp_data;
    le     = (rl > 256) ? 256 : rl;
    stride = sel ? 4 : 1;
    nexp   = (le >= 45) ? (le - 45) / stride + 1 : 0;
    idx = 0; cyc = 0; aborted = 0;

    @(posedge clk); #1;
    rd_valid = 1'b1; rd_data = rd; rd_len = 9'(rl); km_ready = 1'b1;
    @(negedge clk);
    total++;
    if (cur_rd_ready !== 1'b1) begin
      bad++; $display("FAIL %s rd_ready_offer got=%b exp=1", tag, cur_rd_ready);
    end
    @(posedge clk); #1;
    rd_valid = 1'b0;

    if (nexp == 0) begin
      repeat (4) begin
        @(negedge clk);
        total++;
        if ({cur_km_valid, cur_rd_ready} !== 2'b01) begin
          bad++; $display("FAIL %s short_idle valid/ready got=%b%b exp=01", tag, cur_km_valid, cur_rd_ready);
        end
        @(posedge clk); #1;
      end
    end else begin
      while (idx < nexp && !aborted && cyc < 3000) begin
        km_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        exp_data = model_kmer(rd, idx * stride);
        total++;
        if ({cur_km_valid, cur_busy, cur_rd_ready} !== 3'b110) begin
          bad++; $display("FAIL %s flags idx=%0d valid/busy/ready got=%b%b%b exp=110", tag, idx, cur_km_valid, cur_busy, cur_rd_ready);
        end
        total++;
        if (cur_km_data !== exp_data) begin
          bad++; $display("FAIL %s km_data idx=%0d got=%h exp=%h", tag, idx, cur_km_data, exp_data);
        end
        total++;
        if (cur_km_pos !== 8'(idx * stride)) begin
          bad++; $display("FAIL %s km_pos idx=%0d got=%0d exp=%0d", tag, idx, cur_km_pos, idx * stride);
        end
        total++;
        if (cur_km_last !== (idx == nexp - 1)) begin
          bad++; $display("FAIL %s km_last idx=%0d got=%b exp=%b", tag, idx, cur_km_last, (idx == nexp - 1));
        end
        if (abort_kind != 0 && idx * stride == abort_pos) begin
          aborted = 1'b1;
          if (abort_kind == 1) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            @(negedge clk);
            total++;
            if ({cur_km_valid, cur_rd_ready} !== 2'b01) begin
              bad++; $display("FAIL %s after_flush valid/ready got=%b%b exp=01", tag, cur_km_valid, cur_rd_ready);
            end
          end else begin
            reset = 1'b0;
            #1;
            total++;
            if ({cur_km_valid, cur_km_last, cur_busy, cur_km_pos, cur_km_data} !== '0) begin
              bad++; $display("FAIL %s async_reset valid=%b last=%b busy=%b pos=%0d data=%h exp all 0", tag, cur_km_valid, cur_km_last, cur_busy, cur_km_pos, cur_km_data);
            end
            @(posedge clk); #1;
            reset = 1'b1;
            @(negedge clk);
            total++;
            if ({cur_km_valid, cur_rd_ready} !== 2'b01) begin
              bad++; $display("FAIL %s after_reset valid/ready got=%b%b exp=01", tag, cur_km_valid, cur_rd_ready);
            end
          end
        end else begin
          hs = km_ready;
          @(posedge clk); #1;
          if (hs) idx++;
          cyc++;
        end
      end
      km_ready = 1'b1;
      if (!aborted) begin
        total++;
        if (idx !== nexp) begin
          bad++; $display("FAIL %s kmer_count got=%0d exp=%0d (cycle budget)", tag, idx, nexp);
        end
        @(negedge clk);
        total++;
        if ({cur_km_valid, cur_rd_ready} !== 2'b01) begin
          bad++; $display("FAIL %s end_idle valid/ready got=%b%b exp=01", tag, cur_km_valid, cur_rd_ready);
        end
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #3;
    total++;
    if ({cur_km_valid, cur_km_last, cur_busy, cur_km_pos, cur_km_data} !== '0) begin
      bad++; $display("FAIL reset_outputs valid=%b last=%b busy=%b pos=%0d data=%h exp all 0", cur_km_valid, cur_km_last, cur_busy, cur_km_pos, cur_km_data);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    total++;
    if (cur_rd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_rd_ready got=%b exp=1", cur_rd_ready);
    end
  endtask

  task automatic test_full_read();
    do_read(rand_read(), 256, 1'b0, 0, 0, "full256");
  endtask

  task automatic test_short();
    do_read(rand_read(), 44, 1'b0, 0, 0, "len44");
    do_read(rand_read(), 45, 1'b0, 0, 0, "len45");
  endtask

  task automatic test_stride4();
    sel = 1'b1;
    do_read(rand_read(), 53, 1'b0, 0, 0, "s4_len53");
    do_read(rand_read(), 256, 1'b1, 0, 0, "s4_len256_stall");
    sel = 1'b0;
  endtask

  task automatic test_stall();
    logic [511:0] rd;
    rd = rand_read();
    do_read(rd, 256, 1'b0, 0, 0, "nostall_ref");
    do_read(rd, 256, 1'b1, 0, 0, "stall");
  endtask

  task automatic test_flush();
    do_read(rand_read(), 256, 1'b1, 1, 10, "flush_pos10");
    do_read(rand_read(), 100, 1'b0, 0, 0, "after_flush_read");
  endtask

  task automatic test_clamp_reset();
    do_read(rand_read(), 300, 1'b0, 0, 0, "clamp300");
    do_read(rand_read(), 300, 1'b0, 2, 37, "reset_midread");
    do_read(rand_read(), 60, 1'b0, 0, 0, "after_reset_read");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      sel = 1'($urandom_range(0, 1));
      do_read(rand_read(), int'($urandom_range(30, 300)), 1'($urandom_range(0, 1)), 0, 0, "b2b_random");
    end
    sel = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; rd_valid = 1'b0; flush = 1'b0; km_ready = 1'b1;
    rd_data = '0; rd_len = '0;
    test_reset();
    test_full_read();
    test_short();
    test_stride4();
    test_stall();
    test_flush();
    test_clamp_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
